mux_share_arbiter: RTL and testbench

- Sequential controller for the shared 3-input select function F = (A&C) | (~C&B) | (A&B). Functionally this is a 2:1 mux, with C=1 selecting A and C=0 selecting B.
- Two requesters, A and B, each own one data input of the shared mux. This block arbitrates between them round-robin and drives the select line C.
- It enforces a maximum burst length and inserts dead cycles when ownership changes. It also registers the mux output with a valid flag for downstream logic.

---
 rtl/mux_share_arbiter_if.sv | 22 ++
 rtl/mux_share_arbiter.sv | 132 +++++++++++++
 tb/tb_mux_share_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mux_share_arbiter_if.sv
// Signal bundle between the shared-mux arbiter and its requesters / mux datapath.
// The slave side is the arbiter; the master side is the requesters plus the mux return.
interface mux_share_arbiter_if;
    logic REQ_A;
    logic REQ_B;
    logic F_IN;
    logic SEL;
    logic GNT_A;
    logic GNT_B;
    logic DOUT;
    logic DVALID;

    modport slave (
        input  REQ_A, REQ_B, F_IN,
        output SEL, GNT_A, GNT_B, DOUT, DVALID
    );

    modport master (
        output REQ_A, REQ_B, F_IN,
        input  SEL, GNT_A, GNT_B, DOUT, DVALID
    );
endinterface

// File: rtl/mux_share_arbiter.sv
// Round-robin owner of a shared 2:1 mux select line, with burst limit,
// dead cycles on ownership change and a registered data/valid capture.
module mux_share_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned GAP       = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    mux_share_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, GAP_ST} state_t;
    typedef enum logic {SIDE_A, SIDE_B} side_t;

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);
    localparam logic [1:0] GAP_LAST   = (GAP == 0) ? 2'd0 : 2'(GAP - 1);

    state_t     state, state_d;
    side_t      last, last_d;
    side_t      target, target_d;
    logic [3:0] burst_cnt, burst_d;
    logic [1:0] gap_cnt, gap_d;
    logic       sel, sel_d;
    logic       dout, dvalid;

    logic       do_grant, do_switch;
    side_t      grant_to, other;
    logic       own_req, oth_req;

    function automatic logic req_of(input side_t s, input logic ra, input logic rb);
        return (s == SIDE_A) ? ra : rb;
    endfunction

    always_comb begin
        state_d   = state;
        last_d    = last;
        target_d  = target;
        burst_d   = burst_cnt;
        gap_d     = gap_cnt;
        sel_d     = sel;
        do_grant  = 1'b0;
        do_switch = 1'b0;
        grant_to  = last;
        other     = (last == SIDE_A) ? SIDE_B : SIDE_A;
        own_req   = req_of(last, bus.REQ_A, bus.REQ_B);
        oth_req   = req_of(other, bus.REQ_A, bus.REQ_B);

        case (state)
            IDLE: begin
                if (bus.REQ_A || bus.REQ_B) begin
                    do_grant = 1'b1;
                    if (bus.REQ_A && bus.REQ_B)
                        grant_to = other;
                    else
                        grant_to = bus.REQ_A ? SIDE_A : SIDE_B;
                end
            end
            OWN_A, OWN_B: begin
                // While owning, last always names the current owner.
                if (oth_req && (!own_req || burst_cnt == BURST_LAST))
                    do_switch = 1'b1;
                else if (!own_req)
                    state_d = IDLE;
                else if (burst_cnt != BURST_LAST)
                    burst_d = burst_cnt + 4'd1;
            end
            GAP_ST: begin
                if (gap_cnt == GAP_LAST) begin
                    if (req_of(target, bus.REQ_A, bus.REQ_B)) begin
                        do_grant = 1'b1;
                        grant_to = target;
                    end else if (own_req) begin
                        do_grant = 1'b1;
                        grant_to = last;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_cnt + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_switch) begin
            if (GAP == 0) begin
                do_grant = 1'b1;
                grant_to = other;
            end else begin
                state_d  = GAP_ST;
                gap_d    = '0;
                target_d = other;
            end
        end

        if (do_grant) begin
            state_d = (grant_to == SIDE_A) ? OWN_A : OWN_B;
            last_d  = grant_to;
            burst_d = '0;
            sel_d   = (grant_to == SIDE_A);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= SIDE_B;
            target    <= SIDE_A;
            burst_cnt <= '0;
            gap_cnt   <= '0;
            sel       <= 1'b0;
            dout      <= 1'b0;
            dvalid    <= 1'b0;
        end else begin
            state     <= state_d;
            last      <= last_d;
            target    <= target_d;
            burst_cnt <= burst_d;
            gap_cnt   <= gap_d;
            sel       <= sel_d;
            dout      <= bus.F_IN;
            dvalid    <= (state == OWN_A) || (state == OWN_B);
        end
    end

    assign bus.SEL    = sel;
    assign bus.GNT_A  = (state == OWN_A);
    assign bus.GNT_B  = (state == OWN_B);
    assign bus.DOUT   = dout;
    assign bus.DVALID = dvalid;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed bench: default arbiter plus a GAP=0 / MAX_BURST=2 instance, each
// driving a real F=(A&C)|(~C&B)|(A&B) mux built in the bench.
module tb_mux_share_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic dat_a0 = 1'b0, dat_b0 = 1'b0;
    logic dat_a1 = 1'b0, dat_b1 = 1'b0;

    mux_share_arbiter_if bus0 ();
    mux_share_arbiter_if bus1 ();

    assign bus0.F_IN = (dat_a0 & bus0.SEL) | (~bus0.SEL & dat_b0) | (dat_a0 & dat_b0);
    assign bus1.F_IN = (dat_a1 & bus1.SEL) | (~bus1.SEL & dat_b1) | (dat_a1 & dat_b1);

    mux_share_arbiter dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    mux_share_arbiter #(.MAX_BURST(2), .GAP(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packed view {GNT_A, GNT_B, SEL, DVALID}
    function automatic logic [7:0] o0();
        return {4'b0, bus0.GNT_A, bus0.GNT_B, bus0.SEL, bus0.DVALID};
    endfunction

    initial begin
        bus0.REQ_A = 1'b0; bus0.REQ_B = 1'b0;
        bus1.REQ_A = 1'b0; bus1.REQ_B = 1'b0;
        repeat (2) step();
        check("rst_out0", {3'b0, bus0.GNT_A, bus0.GNT_B, bus0.SEL, bus0.DOUT, bus0.DVALID}, 8'h00);
        check("rst_out1", {3'b0, bus1.GNT_A, bus1.GNT_B, bus1.SEL, bus1.DOUT, bus1.DVALID}, 8'h00);
        rst_n = 1'b1;

        // GAP=0, MAX_BURST=2: A,A,B,B,... back to back
        bus1.REQ_A = 1'b1; bus1.REQ_B = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            logic ea;
            step();
            ea = (((k - 1) / 2) % 2) == 0;
            check($sformatf("g0_c%0d", k), {5'b0, bus1.GNT_A, bus1.GNT_B, bus1.SEL}, {5'b0, ea, ~ea, ea});
        end
        bus1.REQ_A = 1'b0; bus1.REQ_B = 1'b0;
        step();
        check("g0_idle", {6'b0, bus1.GNT_A, bus1.GNT_B}, 8'h00);

        // Single requester B for 10 cycles, no forced release
        bus0.REQ_B = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("solo_b_c%0d", k), o0(), {4'b0, 1'b0, 1'b1, 1'b0, (k > 1) ? 1'b1 : 1'b0});
        end
        bus0.REQ_B = 1'b0;
        step();
        check("solo_b_rel", o0(), 8'h01);
        step();
        check("solo_b_idle", o0(), 8'h00);

        // Contention with defaults: 4 grants, 1 gap, alternate; A first since last=B
        bus0.REQ_A = 1'b1; bus0.REQ_B = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            int   ph;
            logic ea, eb, es;
            step();
            ph = (k - 1) % 10;
            ea = ph < 4;
            eb = (ph >= 5) && (ph < 9);
            es = ph < 5;
            check($sformatf("cont_c%0d", k), {5'b0, bus0.GNT_A, bus0.GNT_B, bus0.SEL}, {5'b0, ea, eb, es});
        end
        bus0.REQ_A = 1'b0; bus0.REQ_B = 1'b0;
        step();
        check("cont_idle", {6'b0, bus0.GNT_A, bus0.GNT_B}, 8'h00);

        // Target drops during the gap: A resumes as a fresh burst, B never granted
        bus0.REQ_A = 1'b1;
        repeat (4) step();
        check("drop_own", o0(), 8'h0B);
        bus0.REQ_B = 1'b1;
        step();
        check("drop_gap", {6'b0, bus0.GNT_A, bus0.GNT_B}, 8'h00);
        check("drop_gap_sel", {7'b0, bus0.SEL}, 8'h01);
        bus0.REQ_B = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("drop_resume_c%0d", k), {6'b0, bus0.GNT_A, bus0.GNT_B}, 8'h02);
        end
        bus0.REQ_A = 1'b0;
        repeat (2) step();

        // Reset mid-burst (A owns, burst_cnt=2), then tie goes to A
        dat_a0 = 1'b1; dat_b0 = 1'b0;
        bus0.REQ_A = 1'b1;
        repeat (3) step();
        check("mid_own", {6'b0, bus0.GNT_A, bus0.DOUT}, 8'h03);
        rst_n = 1'b0;
        #2;
        check("mid_rst", {3'b0, bus0.GNT_A, bus0.GNT_B, bus0.SEL, bus0.DOUT, bus0.DVALID}, 8'h00);
        step();
        check("mid_rst_hold", {3'b0, bus0.GNT_A, bus0.GNT_B, bus0.SEL, bus0.DOUT, bus0.DVALID}, 8'h00);
        rst_n = 1'b1;
        bus0.REQ_B = 1'b1;
        step();
        check("post_rst_tie", {5'b0, bus0.GNT_A, bus0.GNT_B, bus0.SEL}, 8'h05);

        // Data path: A=1, B=0 through the real mux
        bus0.REQ_B = 1'b0;
        step();
        check("dp_a", {6'b0, bus0.DOUT, bus0.DVALID}, 8'h03);
        bus0.REQ_A = 1'b0; bus0.REQ_B = 1'b1;
        step();
        check("dp_gap", {5'b0, bus0.GNT_A, bus0.GNT_B, bus0.SEL}, 8'h01);
        step();
        check("dp_own_b", {4'b0, bus0.GNT_B, bus0.SEL, bus0.DOUT, bus0.DVALID}, 8'h0A);
        step();
        check("dp_b", {6'b0, bus0.DOUT, bus0.DVALID}, 8'h01);
        dat_b0 = 1'b1;
        step();
        check("dp_b1", {6'b0, bus0.DOUT, bus0.DVALID}, 8'h03);
        bus0.REQ_B = 1'b0;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
